// File: rtl/multi_btn_debounce.sv
// Multi-channel push-button debouncer: shared tick prescaler, per-channel 4-state FSM.
// Define LONG_PRESS_EN to build the per-channel long-press hold counters.
module multi_btn_debounce #(
    parameter int NCH          = 4,
    parameter int TICK_BITS    = 5,
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] btn,
    output logic [NCH-1:0] level,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] long_press
);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT1,
        S_HIGH,
        S_WAIT0
    } state_t;

    // Four bits so the full STABLE_TICKS range (up to 15) is reachable.
    localparam logic [3:0] CNT_LAST = 4'(STABLE_TICKS - 1);

    logic [NCH-1:0]       r_sync1;
    logic [NCH-1:0]       r_sync2;
    logic [TICK_BITS-1:0] r_pre;
    logic                 w_tick;

    state_t               r_state    [NCH];
    state_t               w_next     [NCH];
    logic [3:0]           r_cnt      [NCH];
    logic [3:0]           w_cnt_next [NCH];
    logic [NCH-1:0]       w_rise_ev;
    logic [NCH-1:0]       w_fall_ev;

    logic [NCH-1:0]       r_level;
    logic [NCH-1:0]       r_rise;
    logic [NCH-1:0]       r_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_pre   <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_pre   <= r_pre + 1'b1;
        end
    end

    assign w_tick = &r_pre;

    // A revert of s is tested first, so it beats a coincident tick.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_next[i]     = r_state[i];
            w_cnt_next[i] = r_cnt[i];
            w_rise_ev[i]  = 1'b0;
            w_fall_ev[i]  = 1'b0;
            case (r_state[i])
                S_LOW: begin
                    if (r_sync2[i]) begin
                        w_next[i]     = S_WAIT1;
                        w_cnt_next[i] = '0;
                    end
                end
                S_WAIT1: begin
                    if (!r_sync2[i]) begin
                        w_next[i] = S_LOW;
                    end else if (w_tick && r_cnt[i] == CNT_LAST) begin
                        w_next[i]    = S_HIGH;
                        w_rise_ev[i] = 1'b1;
                    end else if (w_tick) begin
                        w_cnt_next[i] = r_cnt[i] + 4'd1;
                    end
                end
                S_HIGH: begin
                    if (!r_sync2[i]) begin
                        w_next[i]     = S_WAIT0;
                        w_cnt_next[i] = '0;
                    end
                end
                S_WAIT0: begin
                    if (r_sync2[i]) begin
                        w_next[i] = S_HIGH;
                    end else if (w_tick && r_cnt[i] == CNT_LAST) begin
                        w_next[i]    = S_LOW;
                        w_fall_ev[i] = 1'b1;
                    end else if (w_tick) begin
                        w_cnt_next[i] = r_cnt[i] + 4'd1;
                    end
                end
                default: begin
                    w_next[i] = S_LOW;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                r_state[i] <= S_LOW;
                r_cnt[i]   <= '0;
                r_level[i] <= 1'b0;
                r_rise[i]  <= 1'b0;
                r_fall[i]  <= 1'b0;
            end else begin
                r_state[i] <= w_next[i];
                r_cnt[i]   <= w_cnt_next[i];
                r_level[i] <= (r_state[i] == S_HIGH) ||
                              (r_state[i] == S_WAIT0);
                r_rise[i]  <= w_rise_ev[i];
                r_fall[i]  <= w_fall_ev[i];
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

`ifdef LONG_PRESS_EN
    localparam logic [7:0] HOLD_MAX = 8'(LONG_TICKS);

    logic [7:0]     r_hold [NCH];
    logic [NCH-1:0] r_long;

    // Counter saturates at HOLD_MAX so a single press pulses only once.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                r_hold[i] <= '0;
                r_long[i] <= 1'b0;
            end else begin
                r_long[i] <= 1'b0;
                if (w_rise_ev[i]) begin
                    r_hold[i] <= '0;
                end else if (r_state[i] == S_HIGH && w_tick &&
                             r_hold[i] != HOLD_MAX) begin
                    r_hold[i] <= r_hold[i] + 8'd1;
                    r_long[i] <= (r_hold[i] == HOLD_MAX - 8'd1);
                end
            end
        end
    end

    assign long_press = r_long;
`else
    assign long_press = '0;
`endif

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Directed bench for multi_btn_debounce with an event scoreboard.
// Long-press checks follow the LONG_PRESS_EN macro.
module tb_multi_btn_debounce;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] btn;
    logic [NCH-1:0] level;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] long_press;

    multi_btn_debounce #(
        .NCH          (NCH),
        .TICK_BITS    (2),
        .STABLE_TICKS (3),
        .LONG_TICKS   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int ch;
        int lo;
        int hi;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    int   last_cyc [3][NCH];
    int   e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input int ch,
                        input int lo, input int hi);
        exp_t x;
        x.kind = kind;
        x.ch   = ch;
        x.lo   = lo;
        x.hi   = hi;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind: 0 = rise, 1 = fall, 2 = long_press
    always @(negedge clk) begin
        logic p;
        exp_t x;
        chk("rise_fall_excl", 32'(rise & fall), 32'd0);
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 3; k++) begin
                p = (k == 0) ? rise[c] :
                    (k == 1) ? fall[c] : long_press[c];
                if (p === 1'b1) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", 32'(k * 16 + c),
                            32'hFFFF);
                    end else begin
                        x = q.pop_front();
                        chk("event_id", 32'(k * 16 + c),
                            32'(x.kind * 16 + x.ch));
                        chk("event_window",
                            32'(cyc >= x.lo && cyc <= x.hi), 32'd1);
                        last_cyc[k][c] = cyc;
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < NCH; c++)
                last_cyc[k][c] = -1;
        reset = 1'b1;
        btn   = 4'hF;

        // reset with all buttons held
        repeat (3) begin
            @(negedge clk);
            chk("rst_level", 32'(level), 32'd0);
            chk("rst_long", 32'(long_press), 32'd0);
            chk("rst_pulses", 32'(rise | fall), 32'd0);
        end
        reset = 1'b0;
        step(1);
        chk("post_rst_level", 32'(level), 32'd0);
        chk("post_rst_pulses", 32'(rise | fall), 32'd0);
        btn = 4'h0;
        step(12);
        chk("idle_level", 32'(level), 32'd0);

        // clean press on ch0
        btn[0] = 1'b1;
        e = cyc;
        push(0, 0, e + 12, e + 15);
        step(11);
        chk("press0_early", 32'(level[0]), 32'd0);
        step(5);
        chk("press0_level", 32'(level[0]), 32'd1);
        chk("press0_lag",
            32'(last_cyc[0][0] >= 0 && last_cyc[0][0] < cyc), 32'd1);
        chk("press0_q", 32'(q.size()), 32'd0);
        step(24);

        // bouncing ch1
        for (int i = 0; i < 10; i++) begin
            btn[1] = ~btn[1];
            step(3);
            chk("bounce_level1", 32'(level[1]), 32'd0);
        end
        btn[1] = 1'b1;
        e = cyc;
        push(0, 1, e + 12, e + 15);
        step(16);
        chk("bounce_final", 32'(level), 32'b0011);
        chk("bounce_q", 32'(q.size()), 32'd0);

        // release ch0 while pressing ch2
        btn[0] = 1'b0;
        btn[2] = 1'b1;
        e = cyc;
        push(1, 0, e + 12, e + 15);
        push(0, 2, e + 12, e + 15);
        step(17);
        chk("cross_level", 32'(level), 32'b0110);
        chk("cross_same_cycle", 32'(last_cyc[1][0]),
            32'(last_cyc[0][2]));
        chk("cross_q", 32'(q.size()), 32'd0);

        // ch0 to S_HIGH, ch1 into S_WAIT1, then reset
        btn[0] = 1'b1;
        e = cyc;
        push(0, 0, e + 12, e + 15);
        step(16);
        chk("pre_rst_level0", 32'(level[0]), 32'd1);
        btn[1] = 1'b0;
        e = cyc;
        push(1, 1, e + 12, e + 15);
        step(17);
        chk("pre_rst_level1", 32'(level[1]), 32'd0);
        btn[1] = 1'b1;
        step(5);
        chk("pre_rst_q", 32'(q.size()), 32'd0);
        reset = 1'b1;
        step(1);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_pulses", 32'(rise | fall), 32'd0);
        reset = 1'b0;
        e = cyc;
        push(0, 0, e + 12, e + 15);
        push(0, 1, e + 12, e + 15);
        push(0, 2, e + 12, e + 15);
        step(16);
        chk("rerise_level", 32'(level), 32'b0111);
        chk("rerise_q", 32'(q.size()), 32'd0);

        // long hold on ch3
        btn[3] = 1'b1;
        e = cyc;
        push(0, 3, e + 12, e + 15);
`ifdef LONG_PRESS_EN
        push(2, 3, e + 44, e + 47);
`endif
        step(100);
        chk("long_q", 32'(q.size()), 32'd0);
`ifdef LONG_PRESS_EN
        chk("long_delay",
            32'(last_cyc[2][3] - last_cyc[0][3]), 32'd32);
`else
        chk("long_none", 32'(last_cyc[2][3]), 32'hFFFF_FFFF);
`endif
        chk("long_idle", 32'(long_press), 32'd0);
        chk("long_level", 32'(level), 32'hF);

        // release everything
        btn = 4'h0;
        e = cyc;
        for (int c = 0; c < NCH; c++)
            push(1, c, e + 12, e + 15);
        step(17);
        chk("final_level", 32'(level), 32'd0);
        chk("final_q", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
